sample_sender: RTL and testbench

Transmit-side counterpart of the command decoder. It drains captured samples from the sample FIFO after a capture and serialises them into bytes for the UART transmitter. It sits between `sample_fifo` and `UART_com`, driving `data_out`/`trans_en` through the data side of the top-level transmit mux. Each sample is split into SAMPLE_WIDTH/8 byte groups; disabled groups are skipped.

---
 rtl/sample_sender.sv | 177 +++++++++++++++++
 tb/tb_sample_sender.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_sender.sv
// Drains captured samples from the sample FIFO and serialises each one into UART bytes.
// Define SAMPLE_SENDER_MSB_FIRST_EN to send the most significant byte of each sample first.
module sample_sender #(
  parameter int unsigned SAMPLE_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [15:0]               read_count,
  input  logic [SAMPLE_WIDTH/8-1:0] group_disable,
  output logic                      fifo_rd_en,
  input  logic [SAMPLE_WIDTH-1:0]   fifo_data,
  input  logic                      fifo_valid,
  input  logic                      fifo_empty,
  output logic [7:0]                tran_data,
  output logic                      tran_en,
  input  logic                      tx_busy,
  output logic                      busy,
  output logic                      done,
  output logic                      underrun
);

  localparam int NUM_BYTES = int'(SAMPLE_WIDTH / 8);
  localparam int IdxW      = 3;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitData,
    StScan,
    StSend,
    StWaitAck,
    StWaitTx,
    StNext
  } state_e;

  state_e                    state_q, state_d;
  logic [15:0]               count_q, count_d;
  logic [NUM_BYTES-1:0]      gdis_q, gdis_d;
  logic [SAMPLE_WIDTH-1:0]   sample_q, sample_d;
  logic [IdxW-1:0]           pos_q, pos_d;
  logic [7:0]                tran_data_q, tran_data_d;
  logic                      underrun_q, underrun_d;

  logic [IdxW-1:0]           byte_idx;
  logic [7:0]                cur_byte;
  logic                      cur_dis;

  // pos_q counts scan steps; byte_idx maps a step onto a byte lane
`ifdef SAMPLE_SENDER_MSB_FIRST_EN
  assign byte_idx = IdxW'(NUM_BYTES - 1) - pos_q;
`else
  assign byte_idx = pos_q;
`endif

  always_comb begin
    cur_byte = '0;
    cur_dis  = 1'b1;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_idx == IdxW'(i)) begin
        cur_byte = sample_q[i*8 +: 8];
        cur_dis  = gdis_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    gdis_d      = gdis_q;
    sample_d    = sample_q;
    pos_d       = pos_q;
    tran_data_d = tran_data_q;
    underrun_d  = underrun_q;
    fifo_rd_en  = 1'b0;
    tran_en     = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d    = read_count;
          gdis_d     = group_disable;
          underrun_d = 1'b0;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        if (fifo_empty) begin
          underrun_d = 1'b1;
          done       = 1'b1;
          state_d    = StIdle;
        end else begin
          fifo_rd_en = 1'b1;
          state_d    = StWaitData;
        end
      end
      StWaitData: begin
        if (fifo_valid) begin
          sample_d = fifo_data;
          pos_d    = '0;
          state_d  = StScan;
        end
      end
      StScan: begin
        if (pos_q == IdxW'(NUM_BYTES)) begin
          state_d = StNext;
        end else if (!cur_dis) begin
          tran_data_d = cur_byte;
          state_d     = StSend;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end
      StSend: begin
        if (!tx_busy) begin
          tran_en = 1'b1;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (tx_busy) state_d = StWaitTx;
      end
      StWaitTx: begin
        if (!tx_busy) begin
          pos_d   = pos_q + 1'b1;
          state_d = StScan;
        end
      end
      StNext: begin
        if (count_q == '0) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          count_d = count_q - 1'b1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything: no strobe, no pop, no done, underrun kept as is
    if (abort) begin
      state_d    = StIdle;
      tran_en    = 1'b0;
      fifo_rd_en = 1'b0;
      done       = 1'b0;
      underrun_d = underrun_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      gdis_q      <= '0;
      sample_q    <= '0;
      pos_q       <= '0;
      tran_data_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      gdis_q      <= gdis_d;
      sample_q    <= sample_d;
      pos_q       <= pos_d;
      tran_data_q <= tran_data_d;
      underrun_q  <= underrun_d;
    end
  end

  assign tran_data = tran_data_q;
  assign underrun  = underrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sample_sender.sv
// Bench for sample_sender: FIFO and UART models plus a per-sample byte-order model.
module tb_sample_sender;

  localparam int unsigned SW = 32;
  localparam int unsigned NB = SW / 8;

`ifdef SAMPLE_SENDER_MSB_FIRST_EN
  localparam int GrpGap = 2;
`else
  localparam int GrpGap = 3;
`endif

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [15:0]   read_count;
  logic [NB-1:0] group_disable;
  logic          fifo_rd_en;
  logic [SW-1:0] fifo_data;
  logic          fifo_valid;
  logic          fifo_empty;
  logic [7:0]    tran_data;
  logic          tran_en;
  logic          tx_busy;
  logic          busy;
  logic          done;
  logic          underrun;

  sample_sender #(.SAMPLE_WIDTH(SW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .read_count   (read_count),
    .group_disable(group_disable),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_data    (fifo_data),
    .fifo_valid   (fifo_valid),
    .fifo_empty   (fifo_empty),
    .tran_data    (tran_data),
    .tran_en      (tran_en),
    .tx_busy      (tx_busy),
    .busy         (busy),
    .done         (done),
    .underrun     (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [SW-1:0] fifo_q[$];
  logic [7:0]    exp_q[$];
  logic [7:0]    obs_q[$];
  logic [7:0]    lit1[8];
  logic [7:0]    lit2[2];

  bit            pend = 1'b0;
  logic [SW-1:0] pend_data = '0;
  int            uart_cnt = 0;
  int            uart_len = 2;
  int            cyc = 0;
  int            done_cnt = 0;
  int            pop_cnt = 0;
  int            strobe_cnt = 0;
  int            last_fall_cyc = 0;
  int            exp_gap = -1;
  int            first_valid_cyc = -1;
  int            first_strobe_cyc = -1;
  bit            prev_busy = 1'b0;
  bit            need_rise = 1'b0;
  bit            need_fall = 1'b0;
  bit            have_held = 1'b0;
  logic [7:0]    held = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Environment inputs change on the falling edge; outputs are observed 4 units later.
  always @(negedge clock) begin
    fifo_valid = pend;
    if (pend) fifo_data = pend_data;
    pend       = 1'b0;
    fifo_empty = (fifo_q.size() == 0);
    tx_busy    = (uart_cnt > 0);
    if (uart_cnt > 0) uart_cnt--;
    #4;
    cyc++;
    if (!reset_n) begin
      need_rise = 1'b0;
      need_fall = 1'b0;
      have_held = 1'b0;
      prev_busy = tx_busy;
    end else begin
      if (fifo_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_busy && !tx_busy) last_fall_cyc = cyc;
      prev_busy = tx_busy;
      if (tx_busy && need_rise) begin
        need_rise = 1'b0;
        need_fall = 1'b1;
      end else if (!tx_busy && need_fall) begin
        need_fall = 1'b0;
        have_held = 1'b0;
      end
      if (tx_busy && have_held) check("tran_data_stable", tran_data, held);
      if (tran_en) begin
        check("strobe_while_busy", tx_busy, 0);
        check("strobe_before_handshake", need_rise || need_fall, 0);
        check("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("tran_data", tran_data, exp_q.pop_front());
        if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
        obs_q.push_back(tran_data);
        held      = tran_data;
        have_held = 1'b1;
        need_rise = 1'b1;
        uart_cnt  = uart_len;
        strobe_cnt++;
      end
      if (fifo_rd_en) begin
        check("pop_while_empty", fifo_q.size() > 0, 1);
        if (fifo_q.size() > 0) begin
          pend_data = fifo_q.pop_front();
          pend      = 1'b1;
          pop_cnt++;
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_gap >= 0) check("done_gap", cyc - last_fall_cyc, exp_gap);
      end
    end
  end

  // Expected byte stream: the first min(rc+1, queued) samples, enabled lanes in send order.
  task automatic build_model(input logic [15:0] rc, input logic [NB-1:0] gd,
                             output int npop, output bit und);
    int            req;
    logic [SW-1:0] s;
    req  = int'(rc) + 1;
    npop = (req < fifo_q.size()) ? req : fifo_q.size();
    und  = (req > fifo_q.size());
    exp_q.delete();
    for (int i = 0; i < npop; i++) begin
      s = fifo_q[i];
      for (int k = 0; k < int'(NB); k++) begin
        int b;
`ifdef SAMPLE_SENDER_MSB_FIRST_EN
        b = int'(NB) - 1 - k;
`else
        b = k;
`endif
        if (!gd[b]) exp_q.push_back(s[8*b +: 8]);
      end
    end
  endtask

  task automatic begin_readout(input logic [15:0] rc, input logic [NB-1:0] gd,
                               output int npop, output bit und);
    build_model(rc, gd, npop, und);
    done_cnt         = 0;
    pop_cnt          = 0;
    strobe_cnt       = 0;
    have_held        = 1'b0;
    first_valid_cyc  = -1;
    first_strobe_cyc = -1;
    obs_q.delete();
    read_count    = rc;
    group_disable = gd;
    start         = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic readout(input string tag, input logic [15:0] rc, input logic [NB-1:0] gd,
                         input int gap);
    int npop;
    bit und;
    int b;
    exp_gap = gap;
    begin_readout(rc, gd, npop, und);
    if (npop > 0) check({tag, "_start_to_rd_en"}, fifo_rd_en, 1);
    else          check({tag, "_empty_done"}, done, 1);
    b = 0;
    while (done_cnt == 0 && b < 3000) begin
      step();
      b++;
    end
    repeat (3) step();
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_bytes_left"}, exp_q.size(), 0);
    check({tag, "_pops"}, pop_cnt, npop);
    check({tag, "_underrun"}, underrun, und);
    check({tag, "_busy_after"}, busy, 0);
    exp_gap = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time budget exceeded, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int npop;
    bit und;
    int b;
`ifdef SAMPLE_SENDER_MSB_FIRST_EN
    lit1 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    lit2 = '{8'hCC, 8'hAA};
`else
    lit1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    lit2 = '{8'hAA, 8'hCC};
`endif
    reset_n       = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    read_count    = '0;
    group_disable = '0;
    fifo_valid    = 1'b0;
    fifo_data     = '0;
    fifo_empty    = 1'b1;
    tx_busy       = 1'b0;
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tran_en", tran_en, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_tran_data", tran_data, 0);
    check("rst_underrun", underrun, 0);
    step();
    reset_n = 1'b1;
    step();

    // Two full samples, all lanes enabled
    fifo_q.push_back(32'h44332211);
    fifo_q.push_back(32'h88776655);
    step();
    readout("seq", 16'd1, '0, 2);
    check("seq_count", obs_q.size(), 8);
    for (int i = 0; i < 8; i++) if (i < obs_q.size()) check("seq_byte", obs_q[i], lit1[i]);
    check("valid_to_strobe", first_strobe_cyc - first_valid_cyc, 2);

    // Lanes 1 and 3 disabled, single sample
    fifo_q.push_back(32'hDDCCBBAA);
    step();
    readout("grp", 16'd0, 4'b1010, GrpGap);
    check("grp_count", obs_q.size(), 2);
    for (int i = 0; i < 2; i++) if (i < obs_q.size()) check("grp_byte", obs_q[i], lit2[i]);
    check("grp_single_pop", pop_cnt, 1);

    // Four requested, two available
    fifo_q.push_back(32'h04030201);
    fifo_q.push_back(32'h08070605);
    step();
    readout("und", 16'd3, '0, -1);
    check("und_count", obs_q.size(), 8);
    check("und_flag", underrun, 1);

    // start together with abort in IDLE is ignored and leaves underrun alone
    fifo_q.push_back(32'h0A0B0C0D);
    pop_cnt = 0;
    step();
    read_count = '0;
    start      = 1'b1;
    abort      = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_rd_en", fifo_rd_en, 0);
    repeat (3) step();
    check("sa_pops", pop_cnt, 0);
    check("sa_underrun_kept", underrun, 1);

    // All lanes disabled: samples still popped, nothing sent
    fifo_q.push_back(32'h1A2B3C4D);
    step();
    readout("alldis", 16'd1, 4'hF, -1);
    check("alldis_count", obs_q.size(), 0);

    // Empty FIFO at start
    readout("empty", 16'd0, '0, -1);

    // Slow UART, already busy when the readout begins
    uart_len = 20;
    fifo_q.push_back(32'hCAFEF00D);
    step();
    uart_cnt = 8;
    readout("slow", 16'd0, 4'b0100, 2);
    check("slow_count", obs_q.size(), 3);
    uart_len = 6;

    // Abort while the second byte is in flight
    fifo_q.push_back(32'h44332211);
    fifo_q.push_back(32'h88776655);
    step();
    begin_readout(16'd1, '0, npop, und);
    b = 0;
    while (strobe_cnt < 2 && b < 500) begin
      step();
      b++;
    end
    check("abort_reached", strobe_cnt, 2);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    exp_q.delete();
    repeat (10) step();
    check("abort_no_done", done_cnt, 0);
    check("abort_no_strobe", strobe_cnt, 2);
    check("abort_underrun", underrun, 0);
    check("abort_fifo_left", fifo_q.size(), 1);

    // Reset in the middle of a readout
    begin_readout(16'd0, '0, npop, und);
    b = 0;
    while (strobe_cnt < 1 && b < 500) begin
      step();
      b++;
    end
    check("rst_mid_reached", strobe_cnt, 1);
    step();
    reset_n = 1'b0;
    #1;
    check("rstm_busy", busy, 0);
    check("rstm_done", done, 0);
    check("rstm_tran_en", tran_en, 0);
    check("rstm_rd_en", fifo_rd_en, 0);
    check("rstm_tran_data", tran_data, 0);
    check("rstm_underrun", underrun, 0);
    step();
    step();
    reset_n = 1'b1;
    exp_q.delete();
    step();
    check("rstm_idle", busy, 0);
    repeat (10) step();
    check("rstm_no_done", done_cnt, 0);
    check("rstm_no_strobe", strobe_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
